// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ command engines.
// Read owners are kept in an in-order tag FIFO so responses return to their requester.
module mem_req_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int PA_WIDTH        = 64,
  parameter int DATA_W          = 512,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_isWrite,
  input  logic [NUM_REQ*PA_WIDTH-1:0]       req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]         req_data,
  output logic [NUM_REQ-1:0]                req_grant,
  output logic [NUM_REQ-1:0]                resp_valid,
  output logic [DATA_W-1:0]                 resp_data,
  input  logic [NUM_REQ-1:0]                resp_grant,
  output logic                              mem_req_valid,
  output logic                              mem_req_isWrite,
  output logic [PA_WIDTH-1:0]               mem_req_addr,
  output logic [DATA_W-1:0]                 mem_req_data,
  input  logic                              mem_req_grant,
  input  logic                              mem_resp_valid,
  input  logic [DATA_W-1:0]                 mem_resp_data,
  output logic                              mem_resp_grant,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              resp_orphan_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               orphan_q, orphan_d;
  logic [IDX_W-1:0]   tag_q [MAX_OUTSTANDING];

  logic [NUM_REQ-1:0] elig;
  logic [IDX_W:0]     pick;
  logic [IDX_W-1:0]   sel, owner;
  logic               found, full, empty, fire, push, pop;

  // First set bit of e searching from ptr upward, wrapping at NUM_REQ; MSB flags a hit.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] e,
                                             input logic [IDX_W-1:0]   ptr);
    logic           hit;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0] pos;
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(NUM_REQ)) pos = pos - (IDX_W+1)'(NUM_REQ);
      if (!hit && e[pos[IDX_W-1:0]]) begin
        hit = 1'b1;
        idx = pos[IDX_W-1:0];
      end
    end
    return {hit, idx};
  endfunction

  assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);
  assign elig  = req_valid & (req_isWrite | {NUM_REQ{~full}});
  assign pick  = rr_pick(elig, rr_ptr_q);
  assign found = pick[IDX_W];
  assign sel   = pick[IDX_W-1:0];
  assign owner = tag_q[rd_ptr_q];

  assign mem_req_valid = found && !rst;
  assign fire          = mem_req_valid && mem_req_grant;
  assign push          = fire && !mem_req_isWrite;
  assign pop           = !rst && !empty && mem_resp_valid && resp_grant[owner];

  always_comb begin
    mem_req_isWrite = 1'b0;
    mem_req_addr    = '0;
    mem_req_data    = '0;
    req_grant       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mem_req_valid && sel == IDX_W'(i)) begin
        mem_req_isWrite = req_isWrite[i];
        mem_req_addr    = req_addr[i*PA_WIDTH +: PA_WIDTH];
        mem_req_data    = req_data[i*DATA_W +: DATA_W];
        req_grant[i]    = mem_req_grant;
      end
    end
  end

  // Empty FIFO: any response is an orphan and is swallowed so memory never stalls.
  always_comb begin
    resp_valid     = '0;
    resp_data      = mem_resp_data;
    mem_resp_grant = 1'b0;
    if (!rst) begin
      if (empty) begin
        mem_resp_grant = mem_resp_valid;
      end else begin
        mem_resp_grant = resp_grant[owner];
        for (int i = 0; i < NUM_REQ; i++)
          resp_valid[i] = mem_resp_valid && (owner == IDX_W'(i));
      end
    end
  end

  always_comb begin
    logic [IDX_W:0] nxt;
    nxt      = {1'b0, sel} + (IDX_W+1)'(1);
    rr_ptr_d = rr_ptr_q;
    if (fire) rr_ptr_d = (nxt == (IDX_W+1)'(NUM_REQ)) ? '0 : nxt[IDX_W-1:0];
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    orphan_d = orphan_q || (empty && mem_resp_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      orphan_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      orphan_q <= orphan_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr_q] <= sel;
  end

  assign outstanding     = count_q;
  assign resp_orphan_err = orphan_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_mem_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk, rst;
  logic [1:0]    req_valid, req_isWrite, req_grant, resp_valid, resp_grant;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_data;
  logic [DW-1:0] resp_data, mem_req_data, mem_resp_data;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_valid, mem_req_isWrite, mem_req_grant;
  logic          mem_resp_valid, mem_resp_grant, resp_orphan_err;
  logic [3:0]    outstanding;

  int errors = 0;
  int checks = 0;

  mem_req_arbiter #(.NUM_REQ(2), .PA_WIDTH(AW), .DATA_W(DW), .MAX_OUTSTANDING(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_isWrite(req_isWrite), .req_addr(req_addr), .req_data(req_data),
    .req_grant(req_grant), .resp_valid(resp_valid), .resp_data(resp_data), .resp_grant(resp_grant),
    .mem_req_valid(mem_req_valid), .mem_req_isWrite(mem_req_isWrite), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_grant(mem_req_grant), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .mem_resp_grant(mem_resp_grant), .outstanding(outstanding),
    .resp_orphan_err(resp_orphan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rv, rw;
    logic [31:0] a0, a1;
    logic        mg, mrv;
    logic [31:0] mrd;
    logic [1:0]  rg;
    logic [1:0]  eg;
    logic        emv;
    logic [31:0] ea;
    logic [1:0]  erv;
    logic        emrg;
    logic [3:0]  eo;
  } vec_t;

  vec_t vt[21];

  function automatic vec_t mk(logic [1:0] rv, logic [1:0] rw, logic [31:0] a0, logic [31:0] a1,
                              logic mg, logic mrv, logic [31:0] mrd, logic [1:0] rg,
                              logic [1:0] eg, logic emv, logic [31:0] ea, logic [1:0] erv,
                              logic emrg, logic [3:0] eo);
    vec_t v;
    v.rv = rv; v.rw = rw; v.a0 = a0; v.a1 = a1; v.mg = mg; v.mrv = mrv; v.mrd = mrd; v.rg = rg;
    v.eg = eg; v.emv = emv; v.ea = ea; v.erv = erv; v.emrg = emrg; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rv, input logic [1:0] rw, input logic [31:0] a0,
                       input logic [31:0] a1, input logic mg, input logic mrv,
                       input logic [31:0] mrd, input logic [1:0] rg);
    req_valid = rv; req_isWrite = rw; req_addr = {a1, a0};
    mem_req_grant = mg; mem_resp_valid = mrv; mem_resp_data = mrd; resp_grant = rg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // alternating reads at 0x0 / 0x1000
    vt[0]  = mk(2'b11, 2'b00, 32'h0,  32'h1000, 1, 0, 0, 2'b00, 2'b01, 1, 32'h0,    2'b00, 0, 0);
    vt[1]  = mk(2'b11, 2'b00, 32'h0,  32'h1000, 1, 0, 0, 2'b00, 2'b10, 1, 32'h1000, 2'b00, 0, 1);
    vt[2]  = mk(2'b11, 2'b00, 32'h0,  32'h1000, 1, 0, 0, 2'b00, 2'b01, 1, 32'h0,    2'b00, 0, 2);
    vt[3]  = mk(2'b11, 2'b00, 32'h0,  32'h1000, 1, 0, 0, 2'b00, 2'b10, 1, 32'h1000, 2'b00, 0, 3);
    // drain owners 0,1,0,1 with stalls and a wrong-requester accept
    vt[4]  = mk(2'b00, 2'b00, 0, 0, 1, 1, 32'hD000, 2'b01, 2'b00, 0, 0, 2'b01, 1, 4);
    vt[5]  = mk(2'b00, 2'b00, 0, 0, 1, 1, 32'hD001, 2'b10, 2'b00, 0, 0, 2'b10, 1, 3);
    vt[6]  = mk(2'b00, 2'b00, 0, 0, 1, 1, 32'hD002, 2'b00, 2'b00, 0, 0, 2'b01, 0, 2);
    vt[7]  = mk(2'b00, 2'b00, 0, 0, 1, 1, 32'hD002, 2'b10, 2'b00, 0, 0, 2'b01, 0, 2);
    vt[8]  = mk(2'b00, 2'b00, 0, 0, 1, 1, 32'hD002, 2'b01, 2'b00, 0, 0, 2'b01, 1, 2);
    vt[9]  = mk(2'b00, 2'b00, 0, 0, 1, 1, 32'hD003, 2'b10, 2'b00, 0, 0, 2'b10, 1, 1);
    // req0 reads 0x40, req1 reads 0x80, D1 held 3 cycles
    vt[10] = mk(2'b01, 2'b00, 32'h40, 32'h80, 1, 0, 0, 2'b00, 2'b01, 1, 32'h40, 2'b00, 0, 0);
    vt[11] = mk(2'b10, 2'b00, 32'h40, 32'h80, 1, 0, 0, 2'b00, 2'b10, 1, 32'h80, 2'b00, 0, 1);
    vt[12] = mk(2'b00, 2'b00, 0, 0, 1, 1, 32'hAAAA, 2'b01, 2'b00, 0, 0, 2'b01, 1, 2);
    vt[13] = mk(2'b00, 2'b00, 0, 0, 1, 1, 32'hBBBB, 2'b00, 2'b00, 0, 0, 2'b10, 0, 1);
    vt[14] = mk(2'b00, 2'b00, 0, 0, 1, 1, 32'hBBBB, 2'b00, 2'b00, 0, 0, 2'b10, 0, 1);
    vt[15] = mk(2'b00, 2'b00, 0, 0, 1, 1, 32'hBBBB, 2'b00, 2'b00, 0, 0, 2'b10, 0, 1);
    vt[16] = mk(2'b00, 2'b00, 0, 0, 1, 1, 32'hBBBB, 2'b10, 2'b00, 0, 0, 2'b10, 1, 1);
    vt[17] = mk(2'b00, 2'b00, 0, 0, 1, 0, 0,        2'b00, 2'b00, 0, 0, 2'b00, 0, 0);
    // ungranted request stays selected, then is granted
    vt[18] = mk(2'b11, 2'b00, 32'h40, 32'h80, 0, 0, 0, 2'b00, 2'b00, 1, 32'h40, 2'b00, 0, 0);
    vt[19] = mk(2'b11, 2'b00, 32'h40, 32'h80, 1, 0, 0, 2'b00, 2'b01, 1, 32'h40, 2'b00, 0, 0);
    vt[20] = mk(2'b00, 2'b00, 0, 0, 1, 1, 32'h1234, 2'b01, 2'b00, 0, 0, 2'b01, 1, 1);

    rst = 1'b1;
    req_data = {32'hCAFE0001, 32'hCAFE0000};
    drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00);
    #1;
    chk("rst.grant", req_grant, 2'b00);
    chk("rst.memvalid", mem_req_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst.outstanding", outstanding, 4'd0);
    chk("rst.orphan", resp_orphan_err, 1'b0);

    for (int i = 0; i < 21; i++) begin
      drive(vt[i].rv, vt[i].rw, vt[i].a0, vt[i].a1, vt[i].mg, vt[i].mrv, vt[i].mrd, vt[i].rg);
      #1;
      chk($sformatf("v%0d.grant", i), req_grant, vt[i].eg);
      chk($sformatf("v%0d.memvalid", i), mem_req_valid, vt[i].emv);
      chk($sformatf("v%0d.addr", i), mem_req_addr, vt[i].ea);
      chk($sformatf("v%0d.respvalid", i), resp_valid, vt[i].erv);
      chk($sformatf("v%0d.respdata", i), resp_data, vt[i].mrd);
      chk($sformatf("v%0d.memrespgrant", i), mem_resp_grant, vt[i].emrg);
      chk($sformatf("v%0d.outstanding", i), outstanding, vt[i].eo);
      tick();
    end
    chk("tbl.end_outstanding", outstanding, 4'd0);

    // fill the FIFO with 8 req0 reads
    for (int i = 0; i < 8; i++) begin
      drive(2'b01, 2'b00, 32'h100 + 32'(i), 0, 1, 0, 0, 2'b00);
      #1;
      chk($sformatf("fill%0d.grant", i), req_grant, 2'b01);
      chk($sformatf("fill%0d.outstanding", i), outstanding, 4'(i));
      tick();
    end
    chk("full.outstanding", outstanding, 4'd8);
    drive(2'b11, 2'b10, 32'h108, 32'h200, 1, 0, 0, 2'b00);
    #1;
    chk("full.write_grant", req_grant, 2'b10);
    chk("full.write_addr", mem_req_addr, 32'h200);
    chk("full.write_flag", mem_req_isWrite, 1'b1);
    chk("full.write_data", mem_req_data, 32'hCAFE0001);
    tick();
    chk("full.after_write", outstanding, 4'd8);
    drive(2'b01, 2'b00, 32'h108, 0, 1, 0, 0, 2'b00);
    #1;
    chk("full.read_masked", req_grant, 2'b00);
    chk("full.memvalid_low", mem_req_valid, 1'b0);
    tick();
    drive(2'b01, 2'b00, 32'h108, 0, 1, 1, 32'h5555, 2'b01);
    #1;
    chk("full.pop_grant", req_grant, 2'b00);
    chk("full.pop_resp", resp_valid, 2'b01);
    tick();
    drive(2'b01, 2'b00, 32'h108, 0, 1, 0, 0, 2'b00);
    #1;
    chk("full.ninth_grant", req_grant, 2'b01);
    chk("full.ninth_addr", mem_req_addr, 32'h108);
    chk("full.seven", outstanding, 4'd7);
    tick();
    chk("full.refilled", outstanding, 4'd8);
    for (int i = 0; i < 5; i++) begin
      drive(2'b00, 2'b00, 0, 0, 1, 1, 32'h6000 + 32'(i), 2'b01);
      tick();
    end
    chk("drain.three", outstanding, 4'd3);

    // simultaneous push (req1 read) and pop at outstanding=3
    drive(2'b10, 2'b00, 0, 32'h300, 1, 1, 32'h7000, 2'b01);
    #1;
    chk("pp.grant", req_grant, 2'b10);
    chk("pp.resp", resp_valid, 2'b01);
    tick();
    chk("pp.outstanding", outstanding, 4'd3);
    drive(2'b00, 2'b00, 0, 0, 1, 1, 32'h7001, 2'b11);
    #1;
    chk("pp.order0", resp_valid, 2'b01);
    tick();
    #1;
    chk("pp.order1", resp_valid, 2'b01);
    tick();
    #1;
    chk("pp.order2", resp_valid, 2'b10);
    tick();
    chk("pp.empty", outstanding, 4'd0);

    // orphan response after reset
    drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("orph.clear", resp_orphan_err, 1'b0);
    drive(2'b00, 2'b00, 0, 0, 0, 1, 32'h9999, 2'b00);
    #1;
    chk("orph.memrespgrant", mem_resp_grant, 1'b1);
    chk("orph.respvalid", resp_valid, 2'b00);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("orph.set", resp_orphan_err, 1'b1);
    tick();
    tick();
    chk("orph.sticky", resp_orphan_err, 1'b1);

    // asynchronous reset with two reads outstanding
    drive(2'b01, 2'b00, 32'hA0, 32'hB0, 1, 0, 0, 2'b00);
    tick();
    drive(2'b10, 2'b00, 32'hA0, 32'hB0, 1, 0, 0, 2'b00);
    tick();
    chk("ar.two", outstanding, 4'd2);
    drive(2'b11, 2'b00, 32'hA0, 32'hB0, 1, 1, 32'h4444, 2'b11);
    rst = 1'b1;
    #1;
    chk("ar.outstanding", outstanding, 4'd0);
    chk("ar.grant", req_grant, 2'b00);
    chk("ar.memvalid", mem_req_valid, 1'b0);
    chk("ar.respvalid", resp_valid, 2'b00);
    chk("ar.memrespgrant", mem_resp_grant, 1'b0);
    chk("ar.orphan_clr", resp_orphan_err, 1'b0);
    tick();
    rst = 1'b0;
    drive(2'b00, 2'b00, 0, 0, 1, 1, 32'h4444, 2'b11);
    #1;
    chk("ar.drop", mem_resp_grant, 1'b1);
    chk("ar.noroute", resp_valid, 2'b00);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("ar.orphan", resp_orphan_err, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
